// File: rtl/keypad_pkg.sv
// Shared keypad geometry, scan FSM encoding and event record layout.
package keypad_pkg;

  localparam int unsigned NUM_COLS   = 4;
  localparam int unsigned NUM_ROWS   = 8;
  localparam int unsigned NUM_KEYS   = NUM_COLS * NUM_ROWS;
  localparam int unsigned KEY_W      = 5;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic {
    SETTLE = 1'b0,
    SAMPLE = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic             pressed;
    logic [KEY_W-1:0] key;
  } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// Small event FIFO: push from the scanner, valid/ready on the read side,
// sticky overflow when a push finds it full without a simultaneous pop.
module key_event_fifo
  import keypad_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       push,
  input  key_event_t push_data,
  output logic       valid,
  output key_event_t head,
  input  logic       ready,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  key_event_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop;
  logic             full;
  logic             accept;

  assign valid  = (count != '0);
  assign head   = mem[rd_ptr];
  assign pop    = valid && ready;
  assign full   = (count == FULL_COUNT);
  // A full FIFO still takes the push when the head leaves on the same edge.
  assign accept = push && (!full || pop);

  always_ff @(posedge i_clock) begin
    if (accept) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !accept) begin
        count <= count - 1'b1;
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// 4x8 key matrix scanner: one-hot column strobe, per-key debounce and
// press/release events queued in a small FIFO.
module key_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  output logic [NUM_COLS-1:0] o_column_drive,
  input  logic [NUM_ROWS-1:0] i_rows,
  output logic [NUM_KEYS-1:0] o_key_state,
  output logic                o_event_valid,
  output logic [KEY_W-1:0]    o_event_key,
  output logic                o_event_pressed,
  input  logic                i_event_ready,
  output logic                o_overflow
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] ROW_LAST    = 3'(NUM_ROWS - 1);
  localparam logic [1:0] DEB_LAST    = 2'(DEBOUNCE_SCANS - 1);

  logic [NUM_ROWS-1:0] rows_meta;
  logic [NUM_ROWS-1:0] rows_sync;
  scan_state_t         state;
  logic [7:0]          settle_cnt;
  logic [2:0]          row_idx;
  logic [1:0]          col_idx;
  logic [1:0]          deb_cnt [NUM_KEYS];

  logic [KEY_W-1:0]    cur_key;
  logic                sample_bit;
  logic                cur_state;
  logic [1:0]          cur_cnt;
  logic                evt_gen;
  key_event_t          evt_data;
  key_event_t          head;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rows_meta <= '0;
      rows_sync <= '0;
    end else begin
      rows_meta <= i_rows;
      rows_sync <= rows_meta;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= SETTLE;
      settle_cnt     <= '0;
      row_idx        <= '0;
      col_idx        <= '0;
      o_column_drive <= 4'b0001;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (row_idx == ROW_LAST) begin
            row_idx        <= '0;
            col_idx        <= col_idx + 1'b1;
            o_column_drive <= {o_column_drive[NUM_COLS-2:0], o_column_drive[NUM_COLS-1]};
            state          <= SETTLE;
          end else begin
            row_idx <= row_idx + 1'b1;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  // Key index is column*8 + row, i.e. simply the concatenation.
  assign cur_key    = {col_idx, row_idx};
  assign sample_bit = rows_sync[row_idx];
  assign cur_state  = o_key_state[cur_key];
  assign cur_cnt    = deb_cnt[cur_key];

  always_comb begin
    evt_gen = 1'b0;
    if (state == SAMPLE && sample_bit != cur_state && cur_cnt == DEB_LAST) begin
      evt_gen = 1'b1;
    end
    evt_data.pressed = ~cur_state;
    evt_data.key     = cur_key;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        deb_cnt[k] <= '0;
      end
      o_key_state <= '0;
    end else if (state == SAMPLE) begin
      if (sample_bit == cur_state) begin
        deb_cnt[cur_key] <= '0;
      end else if (evt_gen) begin
        deb_cnt[cur_key]     <= '0;
        o_key_state[cur_key] <= ~cur_state;
      end else begin
        deb_cnt[cur_key] <= cur_cnt + 1'b1;
      end
    end
  end

  key_event_fifo u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .push      (evt_gen),
    .push_data (evt_data),
    .valid     (o_event_valid),
    .head      (head),
    .ready     (i_event_ready),
    .overflow  (o_overflow)
  );

  assign o_event_key     = head.key;
  assign o_event_pressed = head.pressed;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Self-checking bench: behavioural key matrix, scan-aligned stimulus table,
// and an event scoreboard popped on each consumer handshake.
module tb_key_matrix_scanner;
  import keypad_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  o_column_drive;
  logic [7:0]  i_rows;
  logic [31:0] o_key_state;
  logic        o_event_valid;
  logic [4:0]  o_event_key;
  logic        o_event_pressed;
  logic        i_event_ready = 1'b1;
  logic        o_overflow;

  logic [31:0] key_mask = '0;
  logic [31:0] model_state = '0;
  logic [5:0]  exp_q [$];
  logic [5:0]  mon_exp;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] mask;
    int unsigned scans;
    logic [31:0] exp_state;
  } vec_t;
  vec_t vecs [5];

  always #5 i_clock = ~i_clock;

  key_matrix_scanner #(.SETTLE_CYCLES(16), .DEBOUNCE_SCANS(3)) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .o_column_drive  (o_column_drive),
    .i_rows          (i_rows),
    .o_key_state     (o_key_state),
    .o_event_valid   (o_event_valid),
    .o_event_key     (o_event_key),
    .o_event_pressed (o_event_pressed),
    .i_event_ready   (i_event_ready),
    .o_overflow      (o_overflow)
  );

  // Closed switches connect the strobed column to its row lines.
  always @* begin
    i_rows = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (o_column_drive[c]) i_rows = i_rows | key_mask[c*8 +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge i_clock) begin
    if (!i_reset && o_event_valid && i_event_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got key=%0d pressed=%0b expected none",
                 o_event_key, o_event_pressed);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", {26'd0, o_event_pressed, o_event_key}, {26'd0, mon_exp});
      end
    end
  end

  // Returns at the negedge right after the next n column-0 scan starts.
  task automatic wait_scans(input int unsigned n);
    logic [3:0] prev;
    bit         seen;
    for (int unsigned s = 0; s < n; s++) begin
      prev = o_column_drive;
      seen = 1'b0;
      for (int unsigned cyc = 0; cyc < 200 && !seen; cyc++) begin
        @(negedge i_clock);
        if (o_column_drive == 4'b0001 && prev != 4'b0001) seen = 1'b1;
        prev = o_column_drive;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL scan_timeout: got no column-0 start expected one within 200 cycles");
      end
    end
  endtask

  task automatic expect_diff(input logic [31:0] from, input logic [31:0] to);
    logic [4:0] kk;
    for (int unsigned k = 0; k < 32; k++) begin
      kk = 5'(k);
      if (from[k] != to[k]) exp_q.push_back({to[k], kk});
    end
  endtask

  initial begin
    vecs[0] = '{mask: 32'h0000_0400, scans: 3, exp_state: 32'h0000_0400};
    vecs[1] = '{mask: 32'h0000_0000, scans: 3, exp_state: 32'h0000_0000};
    vecs[2] = '{mask: 32'h8000_0001, scans: 4, exp_state: 32'h8000_0001};
    vecs[3] = '{mask: 32'h00A5_0F00, scans: 3, exp_state: 32'h00A5_0F00};
    vecs[4] = '{mask: 32'h0000_0000, scans: 3, exp_state: 32'h0000_0000};

    #12;
    check("rst_column", {28'd0, o_column_drive}, 32'h1);
    check("rst_state", o_key_state, 32'h0);
    check("rst_valid", {31'd0, o_event_valid}, 32'h0);
    check("rst_overflow", {31'd0, o_overflow}, 32'h0);

    @(negedge i_clock);
    i_reset = 1'b0;
    for (int unsigned k = 0; k < 120; k++) begin
      check("column_seq", {28'd0, o_column_drive}, 32'(4'b0001 << ((k / 24) % 4)));
      @(negedge i_clock);
    end

    for (int unsigned i = 0; i < 5; i++) begin
      wait_scans(1);
      expect_diff(model_state, vecs[i].mask);
      key_mask = vecs[i].mask;
      wait_scans(vecs[i].scans);
      repeat (4) @(negedge i_clock);
      check("vec_state", o_key_state, vecs[i].exp_state);
      check("vec_pending", 32'(exp_q.size()), 32'h0);
      model_state = vecs[i].exp_state;
    end

    wait_scans(1);
    for (int unsigned r = 0; r < 3; r++) begin
      key_mask = 32'h0000_0020;
      wait_scans(2);
      key_mask = 32'h0;
      wait_scans(1);
      check("bounce_state", o_key_state, 32'h0);
    end

    @(posedge i_clock);
    #1 i_event_ready = 1'b0;
    wait_scans(1);
    expect_diff(32'h0, 32'h0000_000F);
    key_mask = 32'h0000_003F;
    wait_scans(3);
    repeat (2) @(negedge i_clock);
    check("ovf_flag", {31'd0, o_overflow}, 32'h1);
    check("ovf_state", o_key_state, 32'h0000_003F);
    check("ovf_valid", {31'd0, o_event_valid}, 32'h1);
    for (int unsigned k = 0; k < 4; k++) begin
      check("ovf_head_stable", {26'd0, o_event_pressed, o_event_key}, 32'h20);
      @(negedge i_clock);
    end
    @(posedge i_clock);
    #1 i_event_ready = 1'b1;
    repeat (8) @(negedge i_clock);
    check("ovf_drained", 32'(exp_q.size()), 32'h0);
    check("ovf_empty", {31'd0, o_event_valid}, 32'h0);
    check("ovf_sticky", {31'd0, o_overflow}, 32'h1);

    wait_scans(1);
    repeat (24 + 19) @(negedge i_clock);
    check("mid_sample_col", {28'd0, o_column_drive}, 32'h2);
    #2 i_reset = 1'b1;
    #1;
    check("async_column", {28'd0, o_column_drive}, 32'h1);
    check("async_state", o_key_state, 32'h0);
    check("async_valid", {31'd0, o_event_valid}, 32'h0);
    check("async_overflow", {31'd0, o_overflow}, 32'h0);
    expect_diff(32'h0, 32'h0000_003F);
    repeat (3) @(negedge i_clock);
    check("held_rst_column", {28'd0, o_column_drive}, 32'h1);
    i_reset = 1'b0;
    wait_scans(2);
    check("rearm_not_yet", o_key_state, 32'h0);
    check("rearm_pending", 32'(exp_q.size()), 32'h6);
    wait_scans(1);
    repeat (10) @(negedge i_clock);
    check("rearm_state", o_key_state, 32'h0000_003F);
    check("rearm_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish within 2ms");
    $fatal(1);
  end

endmodule
